// File: rtl/framebuffer_writer.sv
// rtl/framebuffer_writer.sv - pixel/clear/swap write engine for a double-buffered SRAM frame buffer
// Optional out-of-range pixel discard: define FB_BOUNDS_CHECK_EN.
module framebuffer_writer #(
  parameter int          WIDTH      = 640,
  parameter int          HEIGHT     = 480,
  parameter logic [19:0] BUF0_ADDR  = 20'h00000,
  parameter logic [19:0] BUF1_ADDR  = 20'h4B000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [15:0] pix_color,
  input  logic        clear_start,
  input  logic [15:0] clear_color,
  input  logic        swap_req,
  input  logic        completed_frame,
  input  logic        write_grant,
  output logic        write_enable,
  output logic [19:0] write_addr,
  output logic [15:0] write_data,
  output logic [19:0] front_buffer_addr,
  output logic        busy,
  output logic        swap_done
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL    = (AW+1)'(FIFO_DEPTH);
  localparam logic [19:0] WIDTH20 = 20'(WIDTH);
  localparam logic [19:0] LAST    = 20'(WIDTH * HEIGHT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_CLEAR = 3'd3;
  localparam logic [2:0] S_SWAP  = 3'd4;

  logic [35:0]   fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push, pop;

  logic [2:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [19:0] cnt_q, cnt_d;
  logic [35:0] ent_q, ent_d;
  logic [19:0] front_q, front_d, back_q, back_d;
  logic        swap_done_q, swap_done_d;
  logic        clr_pend_q, clr_pend_d, swap_pend_q, swap_pend_d;
  logic [15:0] clr_color_q, clr_color_d;

  logic [35:0] head, ld_ent;
  logic [19:0] ld_addr;
  logic        ld_ok;

  assign pix_ready = (count_q != FULL) && !clr_pend_q && !swap_pend_q;
  assign push      = pix_valid && pix_ready;
  assign head      = fifo_q[rd_ptr_q];

  // Entry layout {x, y, color}; LOAD writes the popped entry, WRITE reloads straight from the head.
  assign ld_ent  = (state_q == S_LOAD) ? ent_q : head;
  assign ld_addr = back_q + ({10'd0, ld_ent[25:16]} * WIDTH20) + {10'd0, ld_ent[35:26]};
`ifdef FB_BOUNDS_CHECK_EN
  assign ld_ok = ({1'b0, ld_ent[35:26]} < 11'(WIDTH)) && ({1'b0, ld_ent[25:16]} < 11'(HEIGHT));
`else
  assign ld_ok = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= {pix_x, pix_y, pix_color};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    ent_d       = ent_q;
    front_d     = front_q;
    back_d      = back_q;
    swap_done_d = 1'b0;
    clr_pend_d  = clr_pend_q;
    swap_pend_d = swap_pend_q;
    clr_color_d = clr_color_q;
    pop         = 1'b0;
    if (clear_start && !clr_pend_q) begin
      clr_pend_d  = 1'b1;
      clr_color_d = clear_color;
    end
    if (swap_req && !swap_pend_q) swap_pend_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (count_q == '0 && clr_pend_q) begin
          state_d = S_CLEAR;
          we_d    = 1'b1;
          addr_d  = back_q;
          data_d  = clr_color_q;
          cnt_d   = '0;
        end else if (count_q == '0 && swap_pend_q) begin
          state_d = S_SWAP;
        end else if (count_q != '0) begin
          pop     = 1'b1;
          ent_d   = head;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        we_d    = ld_ok;
        state_d = S_WRITE;
        if (ld_ok) begin
          addr_d = ld_addr;
          data_d = ld_ent[15:0];
        end
      end
      S_WRITE: begin
        // A discarded entry (we_q low) retires as if granted.
        if (!we_q || write_grant) begin
          if (count_q != '0 && !clr_pend_q && !swap_pend_q) begin
            pop  = 1'b1;
            we_d = ld_ok;
            if (ld_ok) begin
              addr_d = ld_addr;
              data_d = ld_ent[15:0];
            end
          end else begin
            we_d    = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_CLEAR: begin
        if (write_grant) begin
          if (cnt_q == LAST) begin
            we_d       = 1'b0;
            clr_pend_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            cnt_d  = cnt_q + 20'd1;
            addr_d = back_q + cnt_q + 20'd1;
          end
        end
      end
      S_SWAP: begin
        if (completed_frame) begin
          front_d     = back_q;
          back_d      = front_q;
          swap_done_d = 1'b1;
          swap_pend_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      ent_q       <= '0;
      front_q     <= BUF0_ADDR;
      back_q      <= BUF1_ADDR;
      swap_done_q <= 1'b0;
      clr_pend_q  <= 1'b0;
      swap_pend_q <= 1'b0;
      clr_color_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      ent_q       <= ent_d;
      front_q     <= front_d;
      back_q      <= back_d;
      swap_done_q <= swap_done_d;
      clr_pend_q  <= clr_pend_d;
      swap_pend_q <= swap_pend_d;
      clr_color_q <= clr_color_d;
    end
  end

  assign write_enable      = we_q;
  assign write_addr        = addr_q;
  assign write_data        = data_q;
  assign front_buffer_addr = front_q;
  assign swap_done         = swap_done_q;
  assign busy              = (state_q != S_IDLE) || (count_q != '0) || clr_pend_q || swap_pend_q;
endmodule

// File: tb/tb_framebuffer_writer.sv
// tb/tb_framebuffer_writer.sv - directed self-checking bench for framebuffer_writer
module tb_framebuffer_writer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic [15:0] pix_color = '0, clear_color = '0;
  logic        clear_start = 1'b0, swap_req = 1'b0, completed_frame = 1'b0;
  logic        write_grant = 1'b1;
  logic        pix_ready, write_enable, busy, swap_done;
  logic [19:0] write_addr, front_buffer_addr;
  logic [15:0] write_data;

  logic        s_clear_start = 1'b0;
  logic        s_pix_ready, s_write_enable, s_busy, s_swap_done;
  logic [19:0] s_write_addr, s_front_buffer_addr;
  logic [15:0] s_write_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sd_cnt = 0;
  logic [19:0] mq_a[$];
  logic [15:0] mq_d[$];
  int          mq_c[$];
  logic [19:0] sq_a[$];
  logic [15:0] sq_d[$];

  always #5 clock = ~clock;

  framebuffer_writer u_dut (
    .clock(clock), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .clear_start(clear_start), .clear_color(clear_color), .swap_req(swap_req),
    .completed_frame(completed_frame), .write_grant(write_grant),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .front_buffer_addr(front_buffer_addr), .busy(busy), .swap_done(swap_done)
  );

  framebuffer_writer #(.WIDTH(4), .HEIGHT(3), .BUF0_ADDR(20'h00000), .BUF1_ADDR(20'h00100)) u_small (
    .clock(clock), .reset(reset), .pix_valid(1'b0), .pix_ready(s_pix_ready),
    .pix_x(10'd0), .pix_y(10'd0), .pix_color(16'd0),
    .clear_start(s_clear_start), .clear_color(16'hBEEF), .swap_req(1'b0),
    .completed_frame(1'b0), .write_grant(1'b1),
    .write_enable(s_write_enable), .write_addr(s_write_addr), .write_data(s_write_data),
    .front_buffer_addr(s_front_buffer_addr), .busy(s_busy), .swap_done(s_swap_done)
  );

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (write_enable && write_grant) begin
      mq_a.push_back(write_addr);
      mq_d.push_back(write_data);
      mq_c.push_back(cyc);
    end
    if (s_write_enable) begin
      sq_a.push_back(s_write_addr);
      sq_d.push_back(s_write_data);
    end
    if (swap_done) sd_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic push_px(input logic [9:0] x, input logic [9:0] y, input logic [15:0] c);
    logic acc;
    acc = 1'b0;
    pix_x = x; pix_y = y; pix_color = c; pix_valid = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = pix_ready;
      tick();
    end
    pix_valid = 1'b0;
    check_eq("push_accepted", 32'(acc), 32'd1);
  endtask

  task automatic clr_mon();
    mq_a.delete(); mq_d.delete(); mq_c.delete();
  endtask

  initial begin
    int first, nw, acc;
    logic rdy;
    repeat (2) tick();
    check_eq("rst_front", 32'(front_buffer_addr), 32'h00000);
    check_eq("rst_we", 32'(write_enable), 0);
    check_eq("rst_addr", 32'(write_addr), 0);
    check_eq("rst_data", 32'(write_data), 0);
    check_eq("rst_ready", 32'(pix_ready), 1);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_swap_done", 32'(swap_done), 0);
    reset = 1'b0;
    tick();

    // single pixel: write visible two edges after accept, exactly one write
    clr_mon();
    push_px(10'd3, 10'd2, 16'hF800);
    first = -1; nw = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (write_enable) begin
        if (first < 0) begin
          first = c;
          check_eq("px_addr", 32'(write_addr), 32'h4B503);
          check_eq("px_data", 32'(write_data), 32'hF800);
        end
        nw++;
      end
    end
    check_eq("px_latency", first, 2);
    check_eq("px_write_cycles", nw, 1);
    check_eq("px_mon_count", mq_a.size(), 1);

    // x == WIDTH
    clr_mon();
    push_px(10'd640, 10'd0, 16'h1234);
    repeat (8) tick();
`ifdef FB_BOUNDS_CHECK_EN
    check_eq("oob_writes", mq_a.size(), 0);
`else
    check_eq("oob_writes", mq_a.size(), 1);
    if (mq_a.size() == 1) check_eq("oob_addr", 32'(mq_a[0]), 32'h4B280);
`endif
    check_eq("oob_idle_busy", 32'(busy), 0);

    // backpressure: one write stalled, then FIFO fills with 4
    write_grant = 1'b0;
    push_px(10'd0, 10'd0, 16'h1111);
    repeat (3) tick();
    check_eq("stall_we", 32'(write_enable), 1);
    check_eq("stall_addr", 32'(write_addr), 32'h4B000);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      pix_x = 10'(10 + i); pix_y = 10'd1; pix_color = 16'(16'hA001 + i); pix_valid = 1'b1;
      rdy = pix_ready;
      tick();
      if (rdy) acc++;
      check_eq("stall_hold_we", 32'(write_enable), 1);
      check_eq("stall_hold_addr", 32'(write_addr), 32'h4B000);
      check_eq("stall_hold_data", 32'(write_data), 32'h1111);
    end
    pix_valid = 1'b0;
    check_eq("fifo_accepted", acc, 4);
    check_eq("fifo_full_ready", 32'(pix_ready), 0);
    clr_mon();
    write_grant = 1'b1;
    repeat (10) tick();
    check_eq("drain_count", mq_a.size(), 5);
    if (mq_a.size() == 5) begin
      check_eq("drain_a0", 32'(mq_a[0]), 32'h4B000);
      check_eq("drain_d0", 32'(mq_d[0]), 32'h1111);
      for (int i = 1; i < 5; i++) begin
        check_eq("drain_addr", 32'(mq_a[i]), 32'h4B28A + 32'(i - 1));
        check_eq("drain_data", 32'(mq_d[i]), 32'hA001 + 32'(i - 1));
        check_eq("drain_b2b", mq_c[i] - mq_c[i-1], 1);
      end
    end

    // clear on full-size buffer, aborted by reset mid-run
    clr_mon();
    clear_color = 16'h001F; clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (60) tick();
    check_eq("clr_ready", 32'(pix_ready), 0);
    check_eq("clr_busy", 32'(busy), 1);
    check_eq("clr_progress", 32'(mq_a.size() >= 16), 1);
    for (int i = 0; i < 16 && i < mq_a.size(); i++) begin
      check_eq("clr_addr", 32'(mq_a[i]), 32'h4B000 + 32'(i));
      check_eq("clr_data", 32'(mq_d[i]), 32'h001F);
    end
    reset = 1'b1;
    tick();
    check_eq("midrst_front", 32'(front_buffer_addr), 32'h00000);
    check_eq("midrst_we", 32'(write_enable), 0);
    check_eq("midrst_ready", 32'(pix_ready), 1);
    check_eq("midrst_busy", 32'(busy), 0);
    reset = 1'b0;
    tick();

    // complete clear on a 4x3 instance
    sq_a.delete(); sq_d.delete();
    s_clear_start = 1'b1;
    tick();
    s_clear_start = 1'b0;
    tick();
    check_eq("sclr_ready", 32'(s_pix_ready), 0);
    repeat (20) tick();
    check_eq("sclr_count", sq_a.size(), 12);
    for (int i = 0; i < 12 && i < sq_a.size(); i++) begin
      check_eq("sclr_addr", 32'(sq_a[i]), 32'h100 + 32'(i));
      check_eq("sclr_data", 32'(sq_d[i]), 32'hBEEF);
    end
    check_eq("sclr_busy", 32'(s_busy), 0);
    check_eq("sclr_ready_after", 32'(s_pix_ready), 1);

    // swap at frame boundary
    sd_cnt = 0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check_eq("swap_ready", 32'(pix_ready), 0);
    repeat (9) tick();
    check_eq("swap_wait_front", 32'(front_buffer_addr), 32'h00000);
    check_eq("swap_wait_done", 32'(swap_done), 0);
    check_eq("swap_wait_busy", 32'(busy), 1);
    completed_frame = 1'b1;
    tick();
    completed_frame = 1'b0;
    check_eq("swap_front", 32'(front_buffer_addr), 32'h4B000);
    check_eq("swap_done_hi", 32'(swap_done), 1);
    tick();
    check_eq("swap_done_lo", 32'(swap_done), 0);
    check_eq("swap_busy", 32'(busy), 0);
    repeat (3) tick();
    check_eq("swap_pulses", sd_cnt, 1);
    clr_mon();
    push_px(10'd0, 10'd0, 16'h07E0);
    repeat (6) tick();
    check_eq("post_swap_count", mq_a.size(), 1);
    if (mq_a.size() == 1) begin
      check_eq("post_swap_addr", 32'(mq_a[0]), 32'h00000);
      check_eq("post_swap_data", 32'(mq_d[0]), 32'h07E0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
